io_enter_controller: RTL and testbench

Conditions the Enter push-button and sequences I/O instructions for the single-cycle MIPS core. Sits directly upstream of the program counter: while an Input or Output instruction is decoded, it holds the core stalled, waits for a debounced Enter press, and then drives `enter` high long enough for the PC to advance exactly once. It also captures the switch value for Input and latches the display value for Output.

---
 rtl/io_enter_controller_pkg.sv | 26 ++
 rtl/io_enter_controller_if.sv | 32 +++
 rtl/io_enter_controller_button_debouncer.sv | 55 +++++
 rtl/io_enter_controller.sv | 122 ++++++++++++
 tb/tb_io_enter_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_enter_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_pkg
// Purpose : Shared FSM state type and default timing constants for the
//           Enter-button I/O sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } io_state_t;

    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int c_ENTER_HOLD_DEFAULT      = 6;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_enter_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : io_enter_controller_if
// Purpose : Decoder/datapath-side bundle of the I/O sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface io_enter_controller_if #(
    parameter int SW_WIDTH   = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  io_input;
    logic                  io_output;
    logic [SW_WIDTH-1:0]   switches;
    logic [DATA_WIDTH-1:0] reg_data;
    logic                  enter;
    logic                  stall;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] display;
    logic                  display_valid;

    modport master (
        output io_input, io_output, switches, reg_data,
        input  enter, stall, in_data, in_valid, display, display_valid
    );

    modport slave (
        input  io_input, io_output, switches, reg_data,
        output enter, stall, in_data, in_valid, display, display_valid
    );
endinterface
`default_nettype wire

// File: rtl/io_enter_controller_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Purpose : Two-flop synchronizer, counter debouncer and rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module button_debouncer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_button_raw,
    output logic      o_stable,
    output logic      o_rise
);

    localparam int c_CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_stable;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0 <= i_button_raw;
            r_sync1 <= r_sync0;
            r_rise  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync1;
                r_rise   <= r_sync1;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/io_enter_controller.sv
`default_nettype none
// ============================================================================
// Module  : io_enter_controller
// Purpose : Stalls the core on Input/Output instructions and releases a
//           fixed-length Enter pulse per debounced button press.
// Revision: 1.0 - initial release
// ============================================================================
module io_enter_controller
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int ENTER_HOLD      = c_ENTER_HOLD_DEFAULT,
    parameter int SW_WIDTH        = 16,
    parameter int DATA_WIDTH      = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             button_raw,
    io_enter_controller_if.slave  bus
);

    localparam int c_HOLD_W = $clog2(ENTER_HOLD + 1);

    logic                  w_btn_stable;
    logic                  w_btn_rise;
    logic                  w_io_any;
    logic [SW_WIDTH-1:0]   w_sw;
    logic [DATA_WIDTH-1:0] w_sw_ext;

    io_state_t             r_state;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_enter;
    logic                  r_stall;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic                  r_in_valid;
    logic [DATA_WIDTH-1:0] r_display;
    logic                  r_display_valid;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_btn (
        .clk          (clk),
        .reset        (reset),
        .i_button_raw (button_raw),
        .o_stable     (w_btn_stable),
        .o_rise       (w_btn_rise)
    );

    assign w_io_any = bus.io_input | bus.io_output;
    assign w_sw     = bus.switches;
    assign w_sw_ext = DATA_WIDTH'(w_sw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_hold_cnt      <= '0;
            r_enter         <= 1'b0;
            r_stall         <= 1'b0;
            r_in_data       <= '0;
            r_in_valid      <= 1'b0;
            r_display       <= '0;
            r_display_valid <= 1'b0;
        end else begin
            r_in_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_io_any) begin
                        r_state <= ARMED;
                        r_stall <= 1'b1;
                    end
                end
                ARMED: begin
                    // Decode vanished before a press: squash without capture.
                    if (!w_io_any) begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                    end else if (w_btn_rise) begin
                        r_state    <= HOLD;
                        r_enter    <= 1'b1;
                        r_hold_cnt <= '0;
                        if (bus.io_input) begin
                            r_in_data  <= w_sw_ext;
                            r_in_valid <= 1'b1;
                        end else begin
                            r_display       <= bus.reg_data;
                            r_display_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == c_HOLD_W'(ENTER_HOLD - 1)) begin
                        r_state <= RELEASE;
                        r_enter <= 1'b0;
                        r_stall <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A stable low is required before the next press can count.
                    if (!w_btn_stable) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_enter <= 1'b0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enter         = r_enter;
    assign bus.stall         = r_stall;
    assign bus.in_data       = r_in_data;
    assign bus.in_valid      = r_in_valid;
    assign bus.display       = r_display;
    assign bus.display_valid = r_display_valid;

endmodule
`default_nettype wire

// File: tb/tb_io_enter_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_enter_controller
// Purpose : Directed scoreboard bench for the Enter-button I/O sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_io_enter_controller;

    logic clk;
    logic reset;
    logic button_raw;

    io_enter_controller_if #(.SW_WIDTH(16), .DATA_WIDTH(32)) bus ();

    io_enter_controller #(
        .DEBOUNCE_CYCLES (4),
        .ENTER_HOLD      (6),
        .SW_WIDTH        (16),
        .DATA_WIDTH      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button_raw (button_raw),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_in[$];
    int          exp_win[$];
    int          run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard side: capture strobes and Enter window lengths.
    always @(negedge clk) begin
        if (bus.in_valid) begin
            if (exp_in.size() == 0) begin
                chk("spurious_in_valid", {31'd0, bus.in_valid}, 32'd0);
            end else begin
                chk("in_data", bus.in_data, exp_in.pop_front());
                chk("in_valid_first_hold_cycle", run, 32'd0);
                chk("in_valid_with_enter", {31'd0, bus.enter}, 32'd1);
            end
        end
        if (bus.enter) begin
            chk("stall_during_enter", {31'd0, bus.stall}, 32'd1);
            run = run + 1;
        end else if (run != 0) begin
            if (exp_win.size() == 0) chk("spurious_enter_window", run, 32'd0);
            else                     chk("enter_window_len", run, exp_win.pop_front());
            chk("stall_drops_with_enter", {31'd0, bus.stall}, 32'd0);
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press the button and measure clock edges until Enter is first seen.
    task automatic press(input string tag);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        button_raw = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
            seen = bus.enter;
        end
        chk(tag, n, 32'd7);
    endtask

    task automatic wait_enter_low();
        int n;
        n = 0;
        while (bus.enter && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("enter_window_ends", {31'd0, bus.enter}, 32'd0);
    endtask

    initial begin
        int highs;
        reset         = 1'b1;
        button_raw    = 1'b0;
        bus.io_input  = 1'b1;
        bus.io_output = 1'b0;
        bus.switches  = 16'hA5A5;
        bus.reg_data  = 32'h0;

        // Reset state with an Input decode already present.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enter", {31'd0, bus.enter}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_in_data", bus.in_data, 32'd0);
        chk("rst_in_valid", {31'd0, bus.in_valid}, 32'd0);
        chk("rst_display", bus.display, 32'd0);
        chk("rst_display_valid", {31'd0, bus.display_valid}, 32'd0);

        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("stall_not_before_edge", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        chk("stall_after_decode", {31'd0, bus.stall}, 32'd1);
        chk("enter_low_armed", {31'd0, bus.enter}, 32'd0);

        // Input with a clean press.
        exp_in.push_back(32'h0000A5A5);
        exp_win.push_back(6);
        press("input_latency");
        wait_enter_low();
        chk("in_data_held", bus.in_data, 32'h0000A5A5);
        tick();
        bus.io_input = 1'b0;
        button_raw   = 1'b0;
        repeat (12) tick();
        chk("idle_no_stall", {31'd0, bus.stall}, 32'd0);

        // Output with a clean press.
        bus.reg_data  = 32'hDEADBEEF;
        bus.io_output = 1'b1;
        exp_win.push_back(6);
        repeat (3) tick();
        chk("output_stall", {31'd0, bus.stall}, 32'd1);
        press("output_latency");
        wait_enter_low();
        chk("display", bus.display, 32'hDEADBEEF);
        chk("display_valid", {31'd0, bus.display_valid}, 32'd1);
        tick();
        bus.io_output = 1'b0;
        bus.reg_data  = 32'h12345678;
        button_raw    = 1'b0;
        repeat (12) tick();
        chk("display_persists", bus.display, 32'hDEADBEEF);
        chk("display_valid_sticky", {31'd0, bus.display_valid}, 32'd1);

        // Bounce 1,0,1,0 then a stable press: one window only.
        bus.io_input = 1'b1;
        bus.switches = 16'h1234;
        exp_in.push_back(32'h00001234);
        exp_win.push_back(6);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            button_raw = (i % 2 == 0);
            tick();
            chk("bounce_no_enter", {31'd0, bus.enter}, 32'd0);
        end
        press("bounce_latency");
        wait_enter_low();
        tick();
        bus.io_input = 1'b0;
        button_raw   = 1'b0;
        repeat (12) tick();

        // Button held across two consecutive Input instructions.
        bus.io_input = 1'b1;
        bus.switches = 16'h0F0F;
        exp_in.push_back(32'h00000F0F);
        exp_win.push_back(6);
        repeat (2) tick();
        press("held_first_latency");
        wait_enter_low();
        bus.switches = 16'h00FF;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.enter) highs = highs + 1;
        end
        chk("held_no_second_enter", highs, 32'd0);
        chk("held_release_no_stall", {31'd0, bus.stall}, 32'd0);
        button_raw = 1'b0;
        repeat (12) tick();
        chk("second_instr_stalls", {31'd0, bus.stall}, 32'd1);
        exp_in.push_back(32'h000000FF);
        exp_win.push_back(6);
        press("held_second_latency");
        wait_enter_low();
        tick();
        bus.io_input = 1'b0;
        button_raw   = 1'b0;
        repeat (12) tick();

        // Reset during the third HOLD cycle.
        bus.io_input = 1'b1;
        bus.switches = 16'h5555;
        exp_in.push_back(32'h00005555);
        exp_win.push_back(3);
        repeat (2) tick();
        press("reset_case_latency");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset      = 1'b1;
        button_raw = 1'b0;
        #1;
        chk("async_reset_enter", {31'd0, bus.enter}, 32'd0);
        chk("async_reset_stall", {31'd0, bus.stall}, 32'd0);
        chk("async_reset_in_data", bus.in_data, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_stall", {31'd0, bus.stall}, 32'd0);
        repeat (3) tick();
        chk("post_reset_armed", {31'd0, bus.stall}, 32'd1);
        exp_in.push_back(32'h00005555);
        exp_win.push_back(6);
        press("post_reset_latency");
        wait_enter_low();
        tick();
        bus.io_input = 1'b0;
        button_raw   = 1'b0;
        repeat (12) tick();

        chk("in_queue_drained", exp_in.size(), 32'd0);
        chk("window_queue_drained", exp_win.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
